// File: rtl/loac_pkg.sv
// Shared receive-path types and the seven-segment digit patterns used by the display stage.
// Segment order is {g,f,e,d,c,b,a}, active high.
package loac_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam logic [6:0] NUM_0 = 7'h3F;
    localparam logic [6:0] NUM_1 = 7'h06;
    localparam logic [6:0] NUM_2 = 7'h5B;
    localparam logic [6:0] NUM_3 = 7'h4F;
    localparam logic [6:0] NUM_4 = 7'h66;
    localparam logic [6:0] NUM_5 = 7'h6D;
    localparam logic [6:0] NUM_6 = 7'h7D;
    localparam logic [6:0] NUM_7 = 7'h07;
    localparam logic [6:0] NUM_8 = 7'h7F;
    localparam logic [6:0] NUM_9 = 7'h6F;
    localparam logic [6:0] NUM_A = 7'h77;
    localparam logic [6:0] NUM_B = 7'h7C;
    localparam logic [6:0] NUM_C = 7'h39;
    localparam logic [6:0] NUM_D = 7'h5E;
    localparam logic [6:0] NUM_E = 7'h79;
    localparam logic [6:0] NUM_F = 7'h71;
    localparam logic [6:0] VOID  = 7'h00;

endpackage

// File: rtl/nibble_shift_in.sv
// LSB-first shift register: each new bit enters at the top, so the first bit
// received ends up in bit 0 after NBITS_DATA shifts.
module nibble_shift_in #(
    parameter int NBITS_DATA = 4
) (
    input  logic                  clk_2,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  shift_en,
    input  logic                  serial_in,
    output logic [NBITS_DATA-1:0] shift
);

    logic [NBITS_DATA-1:0] shift_reg;
    logic [NBITS_DATA-1:0] shift_next;

    genvar gi;
    generate
        for (gi = 0; gi < NBITS_DATA; gi++) begin : g_bit
            if (gi == NBITS_DATA - 1) begin : g_top
                assign shift_next[gi] = serial_in;
            end else begin : g_low
                assign shift_next[gi] = shift_reg[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk_2) begin
        if (reset || clear) begin
            shift_reg <= '0;
        end else if (shift_en) begin
            shift_reg <= shift_next;
        end
    end

    assign shift = shift_reg;

endmodule

// File: rtl/serial_nibble_rx.sv
// Framed serial nibble receiver: start/data/[even parity]/stop, one bit per clk_2 edge.
// Good frames update data_o with a one-cycle valid_o; bad frames only raise an error pulse.
module serial_nibble_rx
    import loac_pkg::*;
#(
    parameter int NBITS_DATA = 4,
    parameter bit PARITY_EN  = 1'b1,
    parameter int NBITS_CNT  = 4
) (
    input  logic                  clk_2,
    input  logic                  reset,
    input  logic                  serial_i,
    output logic [NBITS_DATA-1:0] data_o,
    output logic                  valid_o,
    output logic                  parity_err_o,
    output logic                  frame_err_o,
    output logic                  busy_o,
    output logic [NBITS_CNT-1:0]  frame_cnt_o
);

    localparam int CNT_W = $clog2(NBITS_DATA + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS_DATA - 1);

    rx_state_t             state_reg, state_next;
    logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
    logic                  parity_bit_reg;
    logic [NBITS_DATA-1:0] shift;
    logic [NBITS_DATA-1:0] data_reg;
    logic [NBITS_CNT-1:0]  cnt_reg;
    logic                  valid_reg, valid_next;
    logic                  perr_reg, perr_next;
    logic                  ferr_reg, ferr_next;
    logic                  busy_reg;

    nibble_shift_in #(
        .NBITS_DATA(NBITS_DATA)
    ) u_shift (
        .clk_2    (clk_2),
        .reset    (reset),
        .clear    (state_reg == IDLE),
        .shift_en (state_reg == DATA),
        .serial_in(serial_i),
        .shift    (shift)
    );

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        valid_next   = 1'b0;
        perr_next    = 1'b0;
        ferr_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (serial_i) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                end
            end
            DATA: begin
                if (bit_cnt_reg == LAST_BIT) begin
                    state_next   = PARITY_EN ? PARITY : STOP;
                    bit_cnt_next = '0;
                end else begin
                    bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                end
            end
            PARITY: state_next = STOP;
            STOP: begin
                // The stop sample is consumed here, so a 1 on this edge never re-arms a frame.
                state_next = IDLE;
                if (serial_i) begin
                    ferr_next = 1'b1;
                end else if (PARITY_EN && ((^shift) ^ parity_bit_reg)) begin
                    perr_next = 1'b1;
                end else begin
                    valid_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= '0;
            parity_bit_reg <= 1'b0;
            data_reg       <= '0;
            cnt_reg        <= '0;
            valid_reg      <= 1'b0;
            perr_reg       <= 1'b0;
            ferr_reg       <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            valid_reg   <= valid_next;
            perr_reg    <= perr_next;
            ferr_reg    <= ferr_next;
            busy_reg    <= (state_next != IDLE);
            if (state_reg == PARITY) begin
                parity_bit_reg <= serial_i;
            end
            if (valid_next) begin
                data_reg <= shift;
                cnt_reg  <= cnt_reg + NBITS_CNT'(1);
            end
        end
    end

    assign data_o       = data_reg;
    assign valid_o      = valid_reg;
    assign parity_err_o = perr_reg;
    assign frame_err_o  = ferr_reg;
    assign busy_o       = busy_reg;
    assign frame_cnt_o  = cnt_reg;

endmodule

// File: tb/tb_serial_nibble_rx.sv
// Bench for serial_nibble_rx: directed frames plus random frames against a frame-level model.
// Instance a uses parity, instance b runs without a parity bit.
module tb_serial_nibble_rx;

    logic       clk_2 = 1'b0;
    logic       reset = 1'b1;
    logic       serial_a = 1'b0;
    logic       serial_b = 1'b0;
    logic [3:0] data_a, data_b, cnt_a, cnt_b;
    logic       valid_a, perr_a, ferr_a, busy_a;
    logic       valid_b, perr_b, ferr_b, busy_b;

    int         vectors = 0;
    int         miscompares = 0;
    int         cycle = 0;
    int         last_valid = -100;
    logic [3:0] m_data = 4'h0;
    logic [3:0] m_cnt = 4'h0;

    always #5 clk_2 = ~clk_2;

    serial_nibble_rx #(.NBITS_DATA(4), .PARITY_EN(1'b1), .NBITS_CNT(4)) dut_a (
        .clk_2(clk_2), .reset(reset), .serial_i(serial_a),
        .data_o(data_a), .valid_o(valid_a), .parity_err_o(perr_a),
        .frame_err_o(ferr_a), .busy_o(busy_a), .frame_cnt_o(cnt_a)
    );

    serial_nibble_rx #(.NBITS_DATA(4), .PARITY_EN(1'b0), .NBITS_CNT(4)) dut_b (
        .clk_2(clk_2), .reset(reset), .serial_i(serial_b),
        .data_o(data_b), .valid_o(valid_b), .parity_err_o(perr_b),
        .frame_err_o(ferr_b), .busy_o(busy_b), .frame_cnt_o(cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic drive(input logic a, input logic b, input logic r);
        @(negedge clk_2);
        serial_a = a;
        serial_b = b;
        reset    = r;
        @(posedge clk_2);
        #1;
        cycle++;
    endtask

    task automatic check_a(input string tag, input logic ev, input logic ep, input logic ef, input logic eb);
        chk({tag, ".valid"}, valid_a, ev);
        chk({tag, ".perr"}, perr_a, ep);
        chk({tag, ".ferr"}, ferr_a, ef);
        chk({tag, ".busy"}, busy_a, eb);
        chk({tag, ".data"}, data_a, m_data);
        chk({tag, ".cnt"}, cnt_a, m_cnt);
        if (valid_a) last_valid = cycle;
    endtask

    // Model: a frame is 7 bits; outcome is known once the stop bit has been sampled.
    task automatic frame_a(input logic [3:0] d, input logic pbad, input logic stopb);
        logic [6:0] bits;
        logic       good;
        bits = {stopb, (^d) ^ pbad, d, 1'b1};
        good = !stopb && !pbad;
        for (int k = 0; k < 7; k++) begin
            drive(bits[k], 1'b0, 1'b0);
            if (k == 6 && good) begin
                m_data = d;
                m_cnt  = m_cnt + 4'd1;
            end
            check_a("frame", k == 6 && good, k == 6 && !stopb && pbad, k == 6 && stopb, k < 6);
        end
        $display("frame data=%h pbad=%0d stop=%0d -> data_o=%h cnt=%0d", d, pbad, stopb, data_a, cnt_a);
    endtask

    task automatic idle_a(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            check_a("idle", 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int         v1;
        logic [5:0] bframe;

        // Reset state
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        check_a("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_b.valid", valid_b, 1'b0);
        chk("reset_b.busy", busy_b, 1'b0);
        chk("reset_b.data", data_b, 4'h0);
        chk("reset_b.cnt", cnt_b, 4'h0);
        idle_a(2);

        // Good, parity-error and stop-error frames
        frame_a(4'hB, 1'b0, 1'b0);
        chk("t1.data", data_a, 4'hB);
        chk("t1.cnt", cnt_a, 4'h1);
        idle_a(1);
        frame_a(4'hB, 1'b1, 1'b0);
        idle_a(1);
        frame_a(4'h0, 1'b0, 1'b1);
        idle_a(2);

        // Back-to-back frames, no idle gap
        frame_a(4'h3, 1'b0, 1'b0);
        v1 = last_valid;
        frame_a(4'hC, 1'b0, 1'b0);
        chk("t4.gap", last_valid - v1, 7);
        chk("t4.data", data_a, 4'hC);
        idle_a(1);

        // Reset during the third data bit
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        m_data = 4'h0;
        m_cnt  = 4'h0;
        check_a("t5.reset", 1'b0, 1'b0, 1'b0, 1'b0);
        frame_a(4'h5, 1'b0, 1'b0);
        chk("t5.data", data_a, 4'h5);
        idle_a(1);

        // Random frames with random gaps and injected errors
        for (int n = 0; n < 30; n++) begin
            idle_a(int'($urandom_range(0, 2)));
            frame_a(4'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        // 17 good frames: the counter must wrap through zero
        for (int n = 0; n < 17; n++) begin
            frame_a(4'($urandom), 1'b0, 1'b0);
        end
        idle_a(1);

        // No-parity instance: 1,1,1,1,1,0
        bframe = 6'b011111;
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, bframe[k], 1'b0);
            chk("t6b.busy", busy_b, k < 5);
        end
        chk("t6b.valid", valid_b, 1'b1);
        chk("t6b.data", data_b, 4'hF);
        chk("t6b.cnt", cnt_b, 4'h1);
        chk("t6b.perr", perr_b, 1'b0);
        chk("t6b.ferr", ferr_b, 1'b0);
        $display("no-parity frame -> data_o=%h cnt=%0d", data_b, cnt_b);
        drive(1'b0, 1'b0, 1'b0);
        chk("t6b.valid_off", valid_b, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
